// File: rtl/oper_start_pipe_if.sv
// Handshake and result bundle between the operand source, oper_start_pipe and the aligner.
// special_o exists only when OPER_START_SPECIAL_EN is defined.
interface oper_start_pipe_if #(
  parameter int unsigned W = 32
);
  localparam int unsigned EW = (W == 64) ? 11 : 8;

  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          add_subt_i;
  logic [W-1:0]  Data_X_i;
  logic [W-1:0]  Data_Y_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-2:0]  DMP_o;
  logic [W-2:0]  DmP_o;
  logic [EW-1:0] exp_diff_o;
  logic          real_op_o;
  logic          sign_final_result_o;
  logic          zero_flag_o;
`ifdef OPER_START_SPECIAL_EN
  logic [2:0]    special_o;
`endif

  modport slave (
    input  flush_i, in_valid_i, add_subt_i, Data_X_i, Data_Y_i, out_ready_i,
`ifdef OPER_START_SPECIAL_EN
    output special_o,
`endif
    output in_ready_o, out_valid_o, DMP_o, DmP_o, exp_diff_o, real_op_o,
    output sign_final_result_o, zero_flag_o
  );

  modport master (
    output flush_i, in_valid_i, add_subt_i, Data_X_i, Data_Y_i, out_ready_i,
`ifdef OPER_START_SPECIAL_EN
    input  special_o,
`endif
    input  in_ready_o, out_valid_o, DMP_o, DmP_o, exp_diff_o, real_op_o,
    input  sign_final_result_o, zero_flag_o
  );
endinterface

// File: rtl/oper_start_pipe.sv
// Two-stage operand front end for FP add/subtract: magnitude ordering, effective op, sign,
// zero flag and exponent difference. Define OPER_START_SPECIAL_EN to add special_o.
module oper_start_pipe #(
  parameter int unsigned W = 32
) (
  input logic              clk,
  input logic              rst,
  oper_start_pipe_if.slave bus
);
  localparam int unsigned EW = (W == 64) ? 11 : 8;

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  x_q, y_q;
  logic          op_q;
  logic          s2_valid_q, s2_valid_d;
  logic [W-2:0]  dmp_q, dmp_d, dmin_q, dmin_d;
  logic [EW-1:0] exp_diff_q, exp_diff_d;
  logic          real_op_q, real_op_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic          s2_free, in_ready, accept, s2_load;
  logic          gt_xy, eq_xy;

  // in_ready uses pre-flush valid bits; a flush only overrides the next state.
  always_comb begin
    s2_free    = !s2_valid_q || bus.out_ready_i;
    in_ready   = !s1_valid_q || s2_free;
    accept     = bus.in_valid_i && in_ready;
    s2_load    = s1_valid_q && s2_free;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (bus.flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
      end else if (s2_load) begin
        s1_valid_d = 1'b0;
      end
      if (s2_load) begin
        s2_valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    gt_xy      = x_q[W-2:0] > y_q[W-2:0];
    eq_xy      = x_q[W-2:0] == y_q[W-2:0];
    dmp_d      = gt_xy ? x_q[W-2:0] : y_q[W-2:0];
    dmin_d     = gt_xy ? y_q[W-2:0] : x_q[W-2:0];
    real_op_d  = x_q[W-1] ^ y_q[W-1] ^ op_q;
    zero_d     = real_op_d && eq_xy;
    exp_diff_d = dmp_d[W-2 -: EW] - dmin_d[W-2 -: EW];
    if (gt_xy) begin
      sign_d = x_q[W-1];
    end else if (eq_xy) begin
      sign_d = real_op_d ? 1'b0 : x_q[W-1];
    end else begin
      sign_d = y_q[W-1] ^ op_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      dmp_q      <= '0;
      dmin_q     <= '0;
      exp_diff_q <= '0;
      real_op_q  <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        x_q  <= bus.Data_X_i;
        y_q  <= bus.Data_Y_i;
        op_q <= bus.add_subt_i;
      end
      if (s2_load) begin
        dmp_q      <= dmp_d;
        dmin_q     <= dmin_d;
        exp_diff_q <= exp_diff_d;
        real_op_q  <= real_op_d;
        sign_q     <= sign_d;
        zero_q     <= zero_d;
      end
    end
  end

`ifdef OPER_START_SPECIAL_EN
  localparam int unsigned MW = W - 1 - EW;

  logic [2:0] special_q, special_d;
  logic       x_inf, y_inf, x_nan, y_nan, nan;

  always_comb begin
    x_inf     = (&x_q[W-2 -: EW]) && !(|x_q[MW-1:0]);
    y_inf     = (&y_q[W-2 -: EW]) && !(|y_q[MW-1:0]);
    x_nan     = (&x_q[W-2 -: EW]) && (|x_q[MW-1:0]);
    y_nan     = (&y_q[W-2 -: EW]) && (|y_q[MW-1:0]);
    // Inf - Inf under an effective subtraction has no defined result.
    nan       = x_nan || y_nan || (x_inf && y_inf && real_op_d);
    special_d = {nan, !nan && (x_inf || y_inf), !(|x_q[W-2:0]) || !(|y_q[W-2:0])};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      special_q <= '0;
    end else if (s2_load) begin
      special_q <= special_d;
    end
  end

  assign bus.special_o = special_q;
`endif

  assign bus.in_ready_o          = in_ready;
  assign bus.out_valid_o         = s2_valid_q;
  assign bus.DMP_o               = dmp_q;
  assign bus.DmP_o               = dmin_q;
  assign bus.exp_diff_o          = exp_diff_q;
  assign bus.real_op_o           = real_op_q;
  assign bus.sign_final_result_o = sign_q;
  assign bus.zero_flag_o         = zero_q;
endmodule

// File: tb/tb_oper_start_pipe.sv
// Scoreboard bench for oper_start_pipe: W=32 by default, W=64 with special_o checks when
// OPER_START_SPECIAL_EN is defined.
module tb_oper_start_pipe;
`ifdef OPER_START_SPECIAL_EN
  localparam int unsigned W = 64;
`else
  localparam int unsigned W = 32;
`endif
  localparam int unsigned EW   = (W == 64) ? 11 : 8;
  localparam int unsigned MW   = W - 1 - EW;
  localparam int unsigned BIAS = (1 << (EW - 1)) - 1;
  localparam int unsigned EMAX = (1 << EW) - 1;

  typedef struct packed {
    logic [W-2:0]  dmp;
    logic [W-2:0]  dmin;
    logic [EW-1:0] ed;
    logic          ro;
    logic          sg;
    logic          zf;
    logic [2:0]    sp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pop_cnt = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];

  oper_start_pipe_if #(.W(W)) bus ();
  oper_start_pipe #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fp(logic s, int unsigned e, logic [MW-1:0] m);
    logic [EW-1:0] ef;
    ef = e[EW-1:0];
    return {s, ef, m};
  endfunction

  function automatic logic is_inf(logic [W-1:0] v);
    return (v[W-2 -: EW] == EMAX[EW-1:0]) && (v[MW-1:0] == '0);
  endfunction

  function automatic logic is_nan(logic [W-1:0] v);
    return (v[W-2 -: EW] == EMAX[EW-1:0]) && (v[MW-1:0] != '0);
  endfunction

  // Reference: order by magnitude, then apply the sign/zero rules of x + (-1)^sub * y.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic sub);
    exp_t e;
    logic eff, nan;
    eff = x[W-1] ^ y[W-1] ^ sub;
    if (x[W-2:0] > y[W-2:0]) begin
      e.dmp  = x[W-2:0];
      e.dmin = y[W-2:0];
      e.sg   = x[W-1];
    end else begin
      e.dmp  = y[W-2:0];
      e.dmin = x[W-2:0];
      if (x[W-2:0] == y[W-2:0]) e.sg = eff ? 1'b0 : x[W-1];
      else                      e.sg = y[W-1] ^ sub;
    end
    e.ed = e.dmp[W-2 -: EW] - e.dmin[W-2 -: EW];
    e.ro = eff;
    e.zf = eff && (x[W-2:0] == y[W-2:0]);
    nan  = is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && eff);
    e.sp = {nan, !nan && (is_inf(x) || is_inf(y)), (x[W-2:0] == '0) || (y[W-2:0] == '0)};
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Monitor/scoreboard: handshakes are sampled on the falling edge before the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      chk("in_ready", 64'(bus.in_ready_o), 64'((sb.size() < 2) || bus.out_ready_i));
      if (sb.size() == 0) chk("idle_valid", 64'(bus.out_valid_o), 64'(0));
      if (bus.flush_i) begin
        sb.delete();
      end else begin
        if (bus.out_valid_o && bus.out_ready_i && sb.size() > 0) begin
          e = sb.pop_front();
          pop_cnt++;
          chk("DMP", 64'(bus.DMP_o), 64'(e.dmp));
          chk("DmP", 64'(bus.DmP_o), 64'(e.dmin));
          chk("exp_diff", 64'(bus.exp_diff_o), 64'(e.ed));
          chk("real_op", 64'(bus.real_op_o), 64'(e.ro));
          chk("sign", 64'(bus.sign_final_result_o), 64'(e.sg));
          chk("zero_flag", 64'(bus.zero_flag_o), 64'(e.zf));
`ifdef OPER_START_SPECIAL_EN
          chk("special", 64'(bus.special_o), 64'(e.sp));
`endif
        end
        if (bus.in_valid_i && bus.in_ready_o)
          sb.push_back(model(bus.Data_X_i, bus.Data_Y_i, bus.add_subt_i));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic sub);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.Data_X_i   = x;
    bus.Data_Y_i   = y;
    bus.add_subt_i = sub;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready_o;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 64'(0), 64'(1));
        done = 1'b1;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin : driver
    logic [W-1:0] one, two, three, neg_one, zero, inf, x, y, mant;
    logic [MW-1:0] m3;
    int p0;
    m3 = '0;
    m3[MW-1] = 1'b1;
    one     = fp(1'b0, BIAS, '0);
    two     = fp(1'b0, BIAS + 1, '0);
    three   = fp(1'b0, BIAS + 1, m3);
    neg_one = fp(1'b1, BIAS, '0);
    zero    = '0;
    inf     = fp(1'b0, EMAX, '0);

    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.add_subt_i  = 1'b0;
    bus.Data_X_i    = '0;
    bus.Data_Y_i    = '0;
    bus.out_ready_i = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'(1));
    chk("rst_DMP", 64'(bus.DMP_o), 64'(0));
    chk("rst_exp_diff", 64'(bus.exp_diff_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready_i = 1'b1;

    // 1.0 + 2.0 with two-cycle latency
    send(one, two, 1'b0);
    chk("lat_s1_only", 64'(bus.out_valid_o), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(bus.out_valid_o), 64'(1));
    chk("t1_DMP", 64'(bus.DMP_o), 64'(two[W-2:0]));
    chk("t1_DmP", 64'(bus.DmP_o), 64'(one[W-2:0]));
    chk("t1_exp_diff", 64'(bus.exp_diff_o), 64'(1));
    chk("t1_real_op", 64'(bus.real_op_o), 64'(0));
    chk("t1_sign", 64'(bus.sign_final_result_o), 64'(0));
    drain();

    // 3.0 - 3.0 held in S2 while -1.0 - 2.0 sits in S1
    bus.out_ready_i = 1'b0;
    send(three, three, 1'b1);
    send(neg_one, two, 1'b1);
    chk("full_in_ready", 64'(bus.in_ready_o), 64'(0));
    chk("t2_real_op", 64'(bus.real_op_o), 64'(1));
    chk("t2_zero", 64'(bus.zero_flag_o), 64'(1));
    chk("t2_sign", 64'(bus.sign_final_result_o), 64'(0));
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_valid", 64'(bus.out_valid_o), 64'(1));
    chk("t3_real_op", 64'(bus.real_op_o), 64'(0));
    chk("t3_sign", 64'(bus.sign_final_result_o), 64'(1));
    chk("t3_DMP", 64'(bus.DMP_o), 64'(two[W-2:0]));
    drain();

`ifdef OPER_START_SPECIAL_EN
    bus.out_ready_i = 1'b0;
    send(inf, inf, 1'b1);
    send(one, zero, 1'b0);
    chk("sp_inf_minus_inf", 64'(bus.special_o), 64'(3'b100));
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("sp_zero_in", 64'(bus.special_o), 64'(3'b001));
    chk("sp_exp_diff", 64'(bus.exp_diff_o), 64'(BIAS));
    drain();
`endif

    // Streaming with out_ready low for three cycles
    p0 = pop_cnt;
    fork
      for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(pop_cnt - p0), 64'(8));

    // Reset with both stages full
    bus.out_ready_i = 1'b0;
    send(one, two, 1'b0);
    send(three, one, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready_o), 64'(1));
    chk("mid_rst_DMP", 64'(bus.DMP_o), 64'(0));
    chk("mid_rst_real_op", 64'(bus.real_op_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(bus.out_valid_o), 64'(0));

    // Flush with both stages full and a pending triple
    bus.out_ready_i = 1'b0;
    send(two, one, 1'b0);
    send(one, three, 1'b1);
    bus.in_valid_i = 1'b1;
    bus.Data_X_i   = three;
    bus.Data_Y_i   = two;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush_valid", 64'(bus.out_valid_o), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'(1));
    bus.out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Flush on an empty pipe: the handshake in that cycle is discarded
    bus.in_valid_i = 1'b1;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_drop_valid", 64'(bus.out_valid_o), 64'(0));

    // Random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = rnd();
      mant = rnd();
      case ($urandom_range(0, 7))
        0: begin
          y = x;
          if ($urandom_range(0, 1) != 0) y[W-1] = ~y[W-1];
        end
        1: y = fp(1'($urandom_range(0, 1)), EMAX, ($urandom_range(0, 1) != 0) ? '0 : mant[MW-1:0]);
        2: y = fp(1'($urandom_range(0, 1)), 0, '0);
        3: y = fp(1'($urandom_range(0, 1)), 32'(x[W-2 -: EW]), mant[MW-1:0]);
        default: y = rnd();
      endcase
      if ($urandom_range(0, 1) != 0) send(x, y, 1'($urandom_range(0, 1)));
      else                           send(y, x, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    bus.out_ready_i = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
